// File: rtl/ship_placement.sv
// Ship placement controller: the player places ships of length 1..N one after another on a
// BOARD_N x BOARD_N occupancy board. Each request is bounds- and overlap-checked before commit.
// Optional feature: define SHIP_UNDO_EN to keep a per-ship mask stack and honour player_undo.
module ship_placement #(
  parameter int BOARD_N = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ships_decided,
  input  logic [2:0]                   player_amount_ships,
  input  logic [2:0]                   player_x,
  input  logic [2:0]                   player_y,
  input  logic                         player_orient,
  input  logic                         player_place,
  input  logic                         player_undo,
  output logic [BOARD_N*BOARD_N-1:0]   player_board,
  output logic [2:0]                   ships_placed,
  output logic                         placement_error,
  output logic                         placement_done
);

  localparam int Cells    = BOARD_N * BOARD_N;
  localparam int MaxShips = 5;

  typedef enum logic [2:0] {StIdle, StPlace, StCheck, StCommit, StDone} state_e;

  state_e           state_q;
  logic [Cells-1:0] board_q;
  logic [2:0]       count_q;
  logic [2:0]       amount_q;
  logic [2:0]       x_q;
  logic [2:0]       y_q;
  logic             orient_q;
  logic             err_q;
  logic             done_q;
  logic             place_prev_q;

  logic             place_rise;
  logic             undo_rise;
  logic             undo_go;
  logic [Cells-1:0] undo_mask;
  logic [Cells-1:0] ship_mask;
  logic             ship_oob;
  logic             ship_overlap;
  logic             amount_ok;

  assign place_rise = player_place & ~place_prev_q;
  assign amount_ok  = (player_amount_ships >= 3'd1) && (player_amount_ships <= 3'd5);

`ifdef SHIP_UNDO_EN
  logic             undo_prev_q;
  logic [Cells-1:0] stack_q [MaxShips];

  assign undo_rise = player_undo & ~undo_prev_q;
  // An undo with nothing placed is swallowed without any effect.
  assign undo_go   = undo_rise & (count_q != 3'd0);
  assign undo_mask = stack_q[count_q - 3'd1];

  // Undo edge history and per-ship mask stack, pushed on every commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      undo_prev_q <= 1'b0;
      for (int i = 0; i < MaxShips; i++) stack_q[i] <= '0;
    end else begin
      undo_prev_q <= player_undo;
      if (state_q == StCommit && ships_decided) stack_q[count_q] <= ship_mask;
    end
  end
`else
  logic unused_undo;
  assign unused_undo = player_undo;
  assign undo_rise   = 1'b0;
  assign undo_go     = 1'b0;
  assign undo_mask   = '0;
`endif

  // Cells of the latched ship (length = ships already placed + 1) and its legality.
  always_comb begin
    int  xi;
    int  yi;
    int  len;
    logic hit;
    xi        = int'(x_q);
    yi        = int'(y_q);
    len       = int'(count_q) + 1;
    hit       = 1'b0;
    ship_mask = '0;
    if (!orient_q) ship_oob = (xi + len > BOARD_N) || (yi >= BOARD_N);
    else           ship_oob = (yi + len > BOARD_N) || (xi >= BOARD_N);
    for (int r = 0; r < BOARD_N; r++) begin
      for (int c = 0; c < BOARD_N; c++) begin
        if (!orient_q) hit = (r == yi) && (c >= xi) && (c < xi + len);
        else           hit = (c == xi) && (r >= yi) && (r < yi + len);
        if (hit) ship_mask[r*BOARD_N+c] = 1'b1;
      end
    end
    ship_overlap = |(ship_mask & board_q);
  end

  // Placement FSM with registered board, count, error and done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      board_q      <= '0;
      count_q      <= 3'd0;
      amount_q     <= 3'd0;
      x_q          <= 3'd0;
      y_q          <= 3'd0;
      orient_q     <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      place_prev_q <= 1'b0;
    end else begin
      place_prev_q <= player_place;
      case (state_q)
        StIdle: begin
          if (ships_decided && amount_ok) begin
            amount_q <= player_amount_ships;
            board_q  <= '0;
            count_q  <= 3'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= StPlace;
          end
        end
        StPlace: begin
          if (!ships_decided) begin
            board_q <= '0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end else if (undo_go) begin
            board_q <= board_q & ~undo_mask;
            count_q <= count_q - 3'd1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
          end else if (place_rise && !undo_rise) begin
            x_q      <= player_x;
            y_q      <= player_y;
            orient_q <= player_orient;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          if (!ships_decided) begin
            board_q <= '0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end else if (ship_oob || ship_overlap) begin
            err_q   <= 1'b1;
            state_q <= StPlace;
          end else begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          if (!ships_decided) begin
            board_q <= '0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end else begin
            board_q <= board_q | ship_mask;
            count_q <= count_q + 3'd1;
            err_q   <= 1'b0;
            if (count_q + 3'd1 == amount_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StPlace;
            end
          end
        end
        StDone: begin
          // Board stays frozen; only undo (or reset) leaves this state.
          if (undo_go) begin
            board_q <= board_q & ~undo_mask;
            count_q <= count_q - 3'd1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= StPlace;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign player_board    = board_q;
  assign ships_placed    = count_q;
  assign placement_error = err_q;
  assign placement_done  = done_q;

endmodule

// File: tb/tb_ship_placement.sv
// Scoreboard bench for ship_placement: stimulus pushes expected output snapshots (with the
// cycle they must appear on, where latency matters); a monitor pops one entry on every
// observed output change and flags any change nobody expected.
module tb_ship_placement;

  localparam int N     = 5;
  localparam int Cells = N * N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ships_decided = 1'b0;
  logic [2:0]       amt = 3'd0;
  logic [2:0]       px = 3'd0;
  logic [2:0]       py = 3'd0;
  logic             por = 1'b0;
  logic             pplace = 1'b0;
  logic             pundo = 1'b0;
  logic [Cells-1:0] board;
  logic [2:0]       placed;
  logic             perr;
  logic             pdone;

  ship_placement #(.BOARD_N(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ships_decided       (ships_decided),
    .player_amount_ships (amt),
    .player_x            (px),
    .player_y            (py),
    .player_orient       (por),
    .player_place        (pplace),
    .player_undo         (pundo),
    .player_board        (board),
    .ships_placed        (placed),
    .placement_error     (perr),
    .placement_done      (pdone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string            name;
    logic [Cells-1:0] board;
    logic [2:0]       n;
    logic             e;
    logic             d;
    int               at;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [Cells-1:0] bm(input int i);
    logic [Cells-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic expect_out(input string name, input logic [Cells-1:0] b, input logic [2:0] n,
                            input logic e, input logic d, input int at);
    exp_t x;
    x.name  = name;
    x.board = b;
    x.n     = n;
    x.e     = e;
    x.d     = d;
    x.at    = at;
    sb.push_back(x);
  endtask

  // Called at posedge+1; the next edge samples the rise.
  task automatic press(input logic [2:0] x, input logic [2:0] y, input logic o, input int hold);
    px     = x;
    py     = y;
    por    = o;
    pplace = 1'b1;
    repeat (hold) @(posedge clk);
    #1 pplace = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Commit lands on the third edge counting the sampling edge.
  task automatic place_ok(input string name, input logic [2:0] x, input logic [2:0] y,
                          input logic o, input logic [Cells-1:0] b, input logic [2:0] n,
                          input logic d);
    expect_out(name, b, n, 1'b0, d, cyc + 3);
    press(x, y, o, 1);
  endtask

  // Rejection shows on the CHECK edge, one before a commit would.
  task automatic place_bad(input string name, input logic [2:0] x, input logic [2:0] y,
                           input logic o, input logic [Cells-1:0] b, input logic [2:0] n);
    expect_out(name, b, n, 1'b1, 1'b0, cyc + 2);
    press(x, y, o, 1);
  endtask

  task automatic do_undo();
    pundo = 1'b1;
    @(posedge clk);
    #1 pundo = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    expect_out(name, '0, 3'd0, 1'b0, 1'b0, -1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({board, placed, perr, pdone} !== '0) begin
      failures++;
      $display("FAIL %s got board=%h placed=%0d err=%b done=%b want all zero",
               name, board, placed, perr, pdone);
    end
  endtask

  // Monitor: every output change must match the oldest outstanding expectation.
  initial begin
    logic [Cells+4:0] last;
    logic [Cells+4:0] now_s;
    exp_t             e;
    last = '0;
    forever begin
      @(negedge clk);
      now_s = {board, placed, perr, pdone};
      if (now_s !== last) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got board=%h placed=%0d err=%b done=%b cyc=%0d",
                   board, placed, perr, pdone, cyc);
        end else begin
          e = sb.pop_front();
          if (board !== e.board || placed !== e.n || perr !== e.e || pdone !== e.d ||
              (e.at >= 0 && cyc != e.at)) begin
            failures++;
            $display("FAIL %s got board=%h placed=%0d err=%b done=%b cyc=%0d want board=%h placed=%0d err=%b done=%b cyc=%0d",
                     e.name, board, placed, perr, pdone, cyc, e.board, e.n, e.e, e.d, e.at);
          end
        end
      end
      last = now_s;
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_state");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Illegal amounts keep IDLE; a place press must not commit anything.
    ships_decided = 1'b1;
    amt = 3'd0;
    repeat (3) @(posedge clk);
    #1 press(3'd0, 3'd0, 1'b0, 1);
    amt = 3'd7;
    repeat (3) @(posedge clk);
    #1 press(3'd0, 3'd0, 1'b0, 1);

    // amount=3, held button commits exactly once, then fill the board.
    amt = 3'd3;
    @(posedge clk);
    #1;
    expect_out("held_place_ship1", bm(0), 3'd1, 1'b0, 1'b0, cyc + 3);
    press(3'd0, 3'd0, 1'b0, 10);
    place_ok("fill_ship2", 3'd0, 3'd1, 1'b0, bm(0) | bm(5) | bm(6), 3'd2, 1'b0);
    place_ok("fill_ship3", 3'd0, 3'd2, 1'b0,
             bm(0) | bm(5) | bm(6) | bm(10) | bm(11) | bm(12), 3'd3, 1'b1);

    // DONE is frozen: place presses and ships_decided falling change nothing.
    press(3'd3, 3'd3, 1'b0, 1);
    ships_decided = 1'b0;
    repeat (3) @(posedge clk);
    #1 ships_decided = 1'b1;
`ifndef SHIP_UNDO_EN
    do_undo();
`endif

    // Edge-of-board accept, then out-of-bounds reject in a fresh run.
    amt = 3'd2;
    do_reset("reset_from_done");
    place_ok("edge_ship1", 3'd0, 3'd0, 1'b0, bm(0), 3'd1, 1'b0);
    place_ok("edge_ship2", 3'd3, 3'd4, 1'b0, bm(0) | bm(23) | bm(24), 3'd2, 1'b1);
    do_reset("reset_fresh_run");
    place_ok("oob_ship1", 3'd0, 3'd0, 1'b0, bm(0), 3'd1, 1'b0);
    place_bad("oob_reject", 3'd4, 3'd4, 1'b0, bm(0), 3'd1);

    // ships_decided falling in PLACE clears everything on the next edge.
    expect_out("decided_fall", '0, 3'd0, 1'b0, 1'b0, cyc + 1);
    ships_decided = 1'b0;
    repeat (2) @(posedge clk);
    #1 ships_decided = 1'b1;
    @(posedge clk);
    #1;

    // Overlap reject, then a vertical ship clears the error and completes.
    place_ok("ovl_ship1", 3'd2, 3'd2, 1'b0, bm(12), 3'd1, 1'b0);
    place_bad("ovl_reject", 3'd2, 3'd2, 1'b0, bm(12), 3'd1);
    place_ok("ovl_ship2_vert", 3'd0, 3'd0, 1'b1, bm(12) | bm(0) | bm(5), 3'd2, 1'b1);
`ifdef SHIP_UNDO_EN
    expect_out("undo_ship2", bm(12), 3'd1, 1'b0, 1'b0, cyc + 1);
    do_undo();
    place_ok("redo_ship2", 3'd3, 3'd3, 1'b1, bm(12) | bm(18) | bm(23), 3'd2, 1'b1);
`else
    do_undo();
`endif

    // Asynchronous reset while the third ship sits in CHECK.
    amt = 3'd3;
    do_reset("reset_before_mid");
    place_ok("mid_ship1", 3'd0, 3'd0, 1'b0, bm(0), 3'd1, 1'b0);
    place_ok("mid_ship2", 3'd0, 3'd1, 1'b0, bm(0) | bm(5) | bm(6), 3'd2, 1'b0);
    expect_out("reset_mid_check", '0, 3'd0, 1'b0, 1'b0, -1);
    px = 3'd0;
    py = 3'd2;
    por = 1'b0;
    pplace = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_zero("reset_async_immediate");
    pplace = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    place_ok("after_reset_ship1", 3'd1, 3'd1, 1'b1, bm(6), 3'd1, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL outstanding_expectations got %0d pending want 0 (next: %s)",
               sb.size(), sb[0].name);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
